reg_scoreboard: RTL and testbench

//  Hazard controller for the 32x32 register file. Tracks in-flight instructions that will write rd,
//  as an in-order queue, and stalls decode on read-after-write or write-after-write hazards.

---
 rtl/reg_scoreboard_pkg.sv | 20 ++
 rtl/reg_scoreboard_if.sv | 38 +++
 rtl/reg_scoreboard_sb_match.sv | 29 ++
 rtl/reg_scoreboard.sv | 138 +++++++++++++
 tb/tb_reg_scoreboard.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register-file hazard scoreboard.
//   REG_ADDR_W : width of a register index (32 architectural registers)
//   REG_ZERO   : index of the hard-wired zero register, never tracked
//   SB_DEPTH   : default number of in-flight writers
//   SB_CNT_W   : occupancy counter width for SB_DEPTH
package reg_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_CNT_W = $clog2(SB_DEPTH) + 1;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    // x0 writes are discarded by the register file, so they never create hazards.
    function automatic logic is_tracked(input reg_idx_t r);
        return r != REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/flush signal bundle for reg_scoreboard.
//   master : pipeline side, drives rdy_in, id_*, wb_*, flush*; sees id_stall, sb_count, sb_error
//   slave  : scoreboard side, the mirror image
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = SB_CNT_W
) ();

    logic             rdy_in;
    logic             id_valid;
    reg_idx_t         id_rs1;
    reg_idx_t         id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    reg_idx_t         id_rd;
    logic             id_wr_rd;
    logic             id_stall;
    logic             wb_valid;
    reg_idx_t         wb_rd;
    logic             flush;
    logic [CNT_W-1:0] flush_keep;
    logic [CNT_W-1:0] sb_count;
    logic             sb_error;

    modport master (
        output rdy_in, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr_rd,
        output wb_valid, wb_rd, flush, flush_keep,
        input  id_stall, sb_count, sb_error
    );

    modport slave (
        input  rdy_in, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr_rd,
        input  wb_valid, wb_rd, flush, flush_keep,
        output id_stall, sb_count, sb_error
    );

endinterface

// File: rtl/reg_scoreboard_sb_match.sv
// Parallel comparator: hit is set when idx equals the rd of any valid entry
// that is not masked out by excl (the entry retiring this cycle).
//   idx       : register index to look up
//   entry_rd  : rd index held by each queue slot
//   entry_vld : slot valid bits
//   excl      : slots to ignore
//   hit       : match found
module reg_scoreboard_sb_match
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  reg_idx_t             idx,
    input  reg_idx_t [DEPTH-1:0] entry_rd,
    input  logic     [DEPTH-1:0] entry_vld,
    input  logic     [DEPTH-1:0] excl,
    output logic                 hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && !excl[i] && (entry_rd[i] == idx)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// In-order scoreboard of pending register writers. Stalls decode on RAW/WAW
// hazards or when full, retires entries from WB in order, and trims younger
// entries on a branch flush.
//   clk, rst : clock, synchronous active-high reset
//   sb       : slave side of reg_scoreboard_if (decode, writeback, flush, status)
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input logic             clk,
    input logic             rst,
    reg_scoreboard_if.slave sb
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    reg_idx_t   [DEPTH-1:0] rd_q, rd_d;
    logic       [DEPTH-1:0] vld_q, vld_d;
    logic       [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic       [CNT_W-1:0] count_q, count_d;
    logic                   err_q, err_d;

    logic                   pop_req, pop, push, full;
    logic       [DEPTH-1:0] pop_mask;
    logic       [CNT_W-1:0] cnt_after_pop, keep;
    logic       [PTR_W-1:0] offs;
    logic                   hit_rs1, hit_rs2, hit_rd;
    logic                   raw1, raw2, waw;

    assign pop_req = sb.rdy_in & sb.wb_valid;
    assign pop     = pop_req & (count_q != '0);

    // The retiring entry is written back this edge, so it no longer blocks decode.
    always_comb begin
        pop_mask = '0;
        if (pop) begin
            pop_mask[head_q] = 1'b1;
        end
    end

    reg_scoreboard_sb_match #(.DEPTH(DEPTH)) u_match_rs1 (
        .idx       (sb.id_rs1),
        .entry_rd  (rd_q),
        .entry_vld (vld_q),
        .excl      (pop_mask),
        .hit       (hit_rs1)
    );

    reg_scoreboard_sb_match #(.DEPTH(DEPTH)) u_match_rs2 (
        .idx       (sb.id_rs2),
        .entry_rd  (rd_q),
        .entry_vld (vld_q),
        .excl      (pop_mask),
        .hit       (hit_rs2)
    );

    reg_scoreboard_sb_match #(.DEPTH(DEPTH)) u_match_rd (
        .idx       (sb.id_rd),
        .entry_rd  (rd_q),
        .entry_vld (vld_q),
        .excl      (pop_mask),
        .hit       (hit_rd)
    );

    assign raw1 = sb.id_use_rs1 & is_tracked(sb.id_rs1) & hit_rs1;
    assign raw2 = sb.id_use_rs2 & is_tracked(sb.id_rs2) & hit_rs2;
    assign waw  = sb.id_wr_rd & is_tracked(sb.id_rd) & hit_rd;
    assign full = (count_q == CNT_W'(DEPTH)) & ~pop;

    assign sb.id_stall = sb.id_valid &
                         (raw1 | raw2 | waw | (full & sb.id_wr_rd & is_tracked(sb.id_rd)));

    assign push = sb.rdy_in & sb.id_valid & ~sb.id_stall & sb.id_wr_rd &
                  is_tracked(sb.id_rd) & ~sb.flush;

    assign cnt_after_pop = count_q - CNT_W'(pop);
    assign keep          = (sb.flush_keep < cnt_after_pop) ? sb.flush_keep : cnt_after_pop;

    always_comb begin
        rd_d    = rd_q;
        vld_d   = vld_q & ~pop_mask;
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;
        offs    = '0;
        if (sb.rdy_in) begin
            if (sb.flush) begin
                // Keep only the `keep` oldest survivors after the pop.
                count_d = keep;
                tail_d  = head_d + PTR_W'(keep);
                for (int i = 0; i < DEPTH; i++) begin
                    offs = PTR_W'(i) - head_d;
                    if (CNT_W'(offs) >= keep) begin
                        vld_d[i] = 1'b0;
                    end
                end
            end else begin
                if (push) begin
                    rd_d[tail_q]  = sb.id_rd;
                    vld_d[tail_q] = 1'b1;
                    tail_d        = tail_q + PTR_W'(1);
                end
                count_d = cnt_after_pop + CNT_W'(push);
            end
            if (pop_req && (count_q == '0)) begin
                err_d = 1'b1;
            end
            if (pop && (sb.wb_rd != rd_q[head_q])) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign sb.sb_count = count_q;
    assign sb.sb_error = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard. A queue model holds the rd indices the
// bench expects to be in flight; occupancy is checked against its size and
// retire indices are taken from its head.
module tb_reg_scoreboard;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [4:0] exp_q[$];
    logic [4:0] rd_tmp;

    reg_scoreboard_if #(.CNT_W(3)) sb_if ();

    reg_scoreboard #(.DEPTH(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb_if.id_valid   = 1'b0;
        sb_if.id_rs1     = '0;
        sb_if.id_rs2     = '0;
        sb_if.id_use_rs1 = 1'b0;
        sb_if.id_use_rs2 = 1'b0;
        sb_if.id_rd      = '0;
        sb_if.id_wr_rd   = 1'b0;
        sb_if.wb_valid   = 1'b0;
        sb_if.wb_rd      = '0;
        sb_if.flush      = 1'b0;
        sb_if.flush_keep = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writer(input logic [4:0] rd);
        idle();
        sb_if.id_valid = 1'b1;
        sb_if.id_rd    = rd;
        sb_if.id_wr_rd = 1'b1;
    endtask

    task automatic reader1(input logic [4:0] rs);
        idle();
        sb_if.id_valid   = 1'b1;
        sb_if.id_rs1     = rs;
        sb_if.id_use_rs1 = 1'b1;
    endtask

    task automatic retire();
        idle();
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = exp_q.pop_front();
        tick();
    endtask

    task automatic check_count(input string tag);
        check(tag, 8'(sb_if.sb_count), 8'(exp_q.size()));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        sb_if.rdy_in = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // 1: reset state, reader with empty queue
        reader1(5'd3);
        #1;
        check("reset_stall", 8'(sb_if.id_stall), 8'd0);
        check("reset_count", 8'(sb_if.sb_count), 8'd0);
        check("reset_error", 8'(sb_if.sb_error), 8'd0);
        tick();

        // 2: RAW on rs2, released in the retire cycle
        writer(5'd5);
        #1;
        check("w5_stall", 8'(sb_if.id_stall), 8'd0);
        tick();
        exp_q.push_back(5'd5);
        check_count("w5_count");
        idle();
        sb_if.id_valid   = 1'b1;
        sb_if.id_rs2     = 5'd5;
        sb_if.id_use_rs2 = 1'b1;
        #1;
        check("raw2_stall", 8'(sb_if.id_stall), 8'd1);
        tick();
        check("raw2_hold", 8'(sb_if.id_stall), 8'd1);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = exp_q.pop_front();
        #1;
        check("raw2_release", 8'(sb_if.id_stall), 8'd0);
        tick();
        check_count("raw2_count");

        // 3: x0 is never tracked
        writer(5'd0);
        #1;
        check("x0_w_stall", 8'(sb_if.id_stall), 8'd0);
        tick();
        check_count("x0_count");
        reader1(5'd0);
        #1;
        check("x0_r_stall", 8'(sb_if.id_stall), 8'd0);
        tick();

        // 4: fill to DEPTH, fifth writer accepted only alongside a retire
        for (int i = 1; i <= 4; i++) begin
            writer(5'(i));
            tick();
            exp_q.push_back(5'(i));
        end
        check_count("full_count");
        writer(5'd6);
        #1;
        check("full_stall", 8'(sb_if.id_stall), 8'd1);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = exp_q.pop_front();
        #1;
        check("full_pop_stall", 8'(sb_if.id_stall), 8'd0);
        tick();
        exp_q.push_back(5'd6);
        check_count("full_pushpop_count");
        writer(5'd3);
        #1;
        check("waw_stall", 8'(sb_if.id_stall), 8'd1);
        while (exp_q.size() > 0) retire();
        check_count("drain_count");
        check("drain_error", 8'(sb_if.sb_error), 8'd0);

        // 5: flush keeps the oldest entry only
        for (int i = 7; i <= 9; i++) begin
            writer(5'(i));
            tick();
            exp_q.push_back(5'(i));
        end
        check_count("pre_flush_count");
        writer(5'd20);
        sb_if.flush      = 1'b1;
        sb_if.flush_keep = 3'd1;
        tick();
        while (exp_q.size() > 1) rd_tmp = exp_q.pop_back();
        check_count("flush_count");
        reader1(5'd8);
        #1;
        check("flushed_rs1_8", 8'(sb_if.id_stall), 8'd0);
        reader1(5'd20);
        #1;
        check("flush_no_push", 8'(sb_if.id_stall), 8'd0);
        reader1(5'd7);
        #1;
        check("kept_rs1_7", 8'(sb_if.id_stall), 8'd1);
        idle();
        sb_if.flush      = 1'b1;
        sb_if.flush_keep = 3'd3;
        tick();
        check_count("flush_saturate");
        retire();
        check_count("post_flush_drain");

        // 6: retire mismatch is sticky; rdy_in low freezes state
        writer(5'd11);
        tick();
        idle();
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = 5'd10;
        tick();
        check("mismatch_error", 8'(sb_if.sb_error), 8'd1);
        check("mismatch_count", 8'(sb_if.sb_count), 8'd0);
        writer(5'd12);
        tick();
        exp_q.push_back(5'd12);
        idle();
        sb_if.rdy_in   = 1'b0;
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = 5'd12;
        tick();
        check_count("frozen_count");
        reader1(5'd12);
        #1;
        check("frozen_stall", 8'(sb_if.id_stall), 8'd1);
        sb_if.rdy_in = 1'b1;
        retire();
        check_count("unfrozen_count");
        check("sticky_error", 8'(sb_if.sb_error), 8'd1);

        // reset mid-operation empties the queue and clears the error
        writer(5'd13);
        tick();
        writer(5'd14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_count", 8'(sb_if.sb_count), 8'd0);
        check("rst_error", 8'(sb_if.sb_error), 8'd0);
        reader1(5'd13);
        #1;
        check("rst_stall", 8'(sb_if.id_stall), 8'd0);

        // retire request on an empty queue is an error and is ignored
        idle();
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = 5'd1;
        tick();
        check("empty_pop_error", 8'(sb_if.sb_error), 8'd1);
        check("empty_pop_count", 8'(sb_if.sb_count), 8'd0);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
